// File: rtl/test_pattern_generator_if.sv
// Video pixel bus for the test pattern generator: raster position and
// pattern controls flow in, registered RGB colour and status flow out.
interface test_pattern_generator_if #(
   parameter int unsigned POS_WIDTH = 10
);
   logic                 inActiveDisplay;
   logic [POS_WIDTH-1:0] hPosCounter;
   logic [POS_WIDTH-1:0] vPosCounter;
   logic [2:0]           patternMode;
   logic [23:0]          solidColor;
   logic [7:0]           redByte;
   logic [7:0]           greenByte;
   logic [7:0]           blueByte;
   logic [2:0]           activeMode;
   logic [7:0]           frameCount;

   // Timing source side: drives raster position and pattern requests.
   modport master (
      output inActiveDisplay, hPosCounter, vPosCounter, patternMode, solidColor,
      input  redByte, greenByte, blueByte, activeMode, frameCount
   );

   // Generator side: consumes position, produces colour.
   modport slave (
      input  inActiveDisplay, hPosCounter, vPosCounter, patternMode, solidColor,
      output redByte, greenByte, blueByte, activeMode, frameCount
   );
endinterface

// File: rtl/test_pattern_generator.sv
// Test pattern generator: colour bars, grey ramp, checkerboard, solid colour
// and a moving white column, with a fixed input-to-pixel latency.
module test_pattern_generator #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned POS_WIDTH  = 10,
   parameter int unsigned PIPE_DELAY = 2,
   parameter int unsigned CHECK_LOG2 = 5
) (
   input  logic                    pixelClock,
   input  logic                    reset,
   test_pattern_generator_if.slave bus
);
   localparam int unsigned BAR_W = H_ACTIVE / 8;

   typedef enum logic [2:0] {
      MODE_BARS  = 3'd0,
      MODE_RAMP  = 3'd1,
      MODE_CHECK = 3'd2,
      MODE_SOLID = 3'd3,
      MODE_MOVE  = 3'd4,
      MODE_RSVD5 = 3'd5,
      MODE_RSVD6 = 3'd6,
      MODE_RSVD7 = 3'd7
   } mode_e;

   mode_e                mode_q, mode_d;
   logic [23:0]          solid_q, solid_d;
   logic [POS_WIDTH-1:0] bar_pos_q, bar_pos_d;
   logic [7:0]           frame_cnt_q, frame_cnt_d;
   logic [2:0]           bar_idx_q, bar_idx_d;
   logic [31:0]          bar_edge_q, bar_edge_d;
   logic [23:0]          pipe_q [PIPE_DELAY];
   logic [23:0]          pipe_d [PIPE_DELAY];

   logic [31:0] h32, v32, bar32;
   logic        frame_start, in_area;
   logic [7:0]  grey;
   logic [23:0] colour;

   assign h32         = 32'(bus.hPosCounter);
   assign v32         = 32'(bus.vPosCounter);
   assign frame_start = bus.inActiveDisplay && (bus.hPosCounter == '0) && (bus.vPosCounter == '0);
   assign in_area     = bus.inActiveDisplay && (h32 < H_ACTIVE) && (v32 < V_ACTIVE);

   // Per-frame state: mode, solid colour, bar position and frame count load at the boundary.
   // The boundary pixel itself already renders with the freshly loaded values.
   always_comb begin
      mode_d      = mode_q;
      solid_d     = solid_q;
      bar_pos_d   = bar_pos_q;
      frame_cnt_d = frame_cnt_q;
      if (frame_start) begin
         mode_d      = mode_e'(bus.patternMode);
         solid_d     = bus.solidColor;
         frame_cnt_d = frame_cnt_q + 8'd1;
         if (32'(bar_pos_q) + 32'd4 >= H_ACTIVE) bar_pos_d = '0;
         else                                    bar_pos_d = bar_pos_q + POS_WIDTH'(4);
      end
   end

   // Colour-bar index tracking: restarts at hPos 0 and steps when hPos reaches the next
   // bar edge, so a step-by-one raster never needs a divider; saturates at the last bar.
   always_comb begin
      bar_idx_d  = bar_idx_q;
      bar_edge_d = bar_edge_q;
      if (bus.hPosCounter == '0) begin
         bar_idx_d  = '0;
         bar_edge_d = BAR_W;
      end else if ((h32 >= bar_edge_q) && (bar_idx_q != 3'd7)) begin
         bar_idx_d  = bar_idx_q + 3'd1;
         bar_edge_d = bar_edge_q + BAR_W;
      end
   end

   assign grey  = 8'((h32 << 8) / H_ACTIVE);
   assign bar32 = 32'(bar_pos_d);

   // Pixel colour for the current position; anything outside the active area is black.
   always_comb begin
      colour = '0;
      if (in_area) begin
         case (mode_d)
            MODE_BARS:  colour = {{8{~bar_idx_d[1]}}, {8{~bar_idx_d[2]}}, {8{~bar_idx_d[0]}}};
            MODE_RAMP:  colour = {grey, grey, grey};
            MODE_CHECK: colour = (bus.hPosCounter[CHECK_LOG2] ^ bus.vPosCounter[CHECK_LOG2]) ? '0 : '1;
            MODE_SOLID: colour = solid_d;
            MODE_MOVE:  colour = ((h32 >= bar32) && (h32 < bar32 + 32'd8)) ? '1 : '0;
            default:    colour = '0;
         endcase
      end
   end

   // Delay line: stage 0 captures the new pixel, later stages shift it toward the outputs.
   always_comb begin
      pipe_d[0] = colour;
      for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // State registers with asynchronous reset to black / mode 0.
   always_ff @(posedge pixelClock or posedge reset) begin
      if (reset) begin
         mode_q      <= MODE_BARS;
         solid_q     <= '0;
         bar_pos_q   <= '0;
         frame_cnt_q <= '0;
         bar_idx_q   <= '0;
         bar_edge_q  <= BAR_W;
         for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         mode_q      <= mode_d;
         solid_q     <= solid_d;
         bar_pos_q   <= bar_pos_d;
         frame_cnt_q <= frame_cnt_d;
         bar_idx_q   <= bar_idx_d;
         bar_edge_q  <= bar_edge_d;
         pipe_q      <= pipe_d;
      end
   end

   assign bus.redByte    = pipe_q[PIPE_DELAY-1][23:16];
   assign bus.greenByte  = pipe_q[PIPE_DELAY-1][15:8];
   assign bus.blueByte   = pipe_q[PIPE_DELAY-1][7:0];
   assign bus.activeMode = mode_q;
   assign bus.frameCount = frame_cnt_q;
endmodule

// File: tb/tb_test_pattern_generator.sv
// Directed bench for test_pattern_generator at default parameters
// (640x480, PIPE_DELAY 2, 32-pixel checker squares).
module tb_test_pattern_generator;
   localparam int H_TOT = 700;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   test_pattern_generator_if #(.POS_WIDTH(10)) bus ();

   test_pattern_generator #(
      .H_ACTIVE  (640),
      .V_ACTIVE  (480),
      .POS_WIDTH (10),
      .PIPE_DELAY(2),
      .CHECK_LOG2(5)
   ) dut (
      .pixelClock(clk),
      .reset     (rst),
      .bus       (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [23:0] out_line [H_TOT];
   logic [23:0] rgb;
   assign rgb = {bus.redByte, bus.greenByte, bus.blueByte};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One pixel: present inputs, advance one clock, settle 1 time unit past the edge.
   task automatic pix(input logic a, input int h, input int v);
      bus.inActiveDisplay = a;
      bus.hPosCounter     = 10'(h);
      bus.vPosCounter     = 10'(v);
      @(posedge clk);
      #1;
   endtask

   // Sweep a line; with 2-cycle latency the output after pixel h belongs to pixel h-1.
   task automatic run_line(input int v, input int hole, input int chg_h,
                           input logic [2:0] chg_mode, input bit act_all);
      for (int h = 0; h < H_TOT; h++) begin
         if (h == chg_h) bus.patternMode = chg_mode;
         pix((act_all || h < 640) && (h != hole), h, v);
         if (h > 0) out_line[h-1] = rgb;
      end
   endtask

   task automatic boundary();
      pix(1'b1, 0, 0);
      pix(1'b0, 1, 1);
   endtask

   initial begin
      bus.inActiveDisplay = 1'b0;
      bus.hPosCounter     = '0;
      bus.vPosCounter     = '0;
      bus.patternMode     = 3'd0;
      bus.solidColor      = 24'h000000;
      @(posedge clk);
      #1;
      chk("reset_rgb", 32'(rgb), 32'h0);
      chk("reset_mode", 32'(bus.activeMode), 32'd0);
      chk("reset_fcnt", 32'(bus.frameCount), 32'd0);
      rst = 1'b0;

      // Colour bars, first frame
      run_line(0, -1, -1, 3'd0, 1'b0);
      chk("bars_h0", 32'(out_line[0]), 32'hFFFFFF);
      chk("bars_h79", 32'(out_line[79]), 32'hFFFFFF);
      chk("bars_h80", 32'(out_line[80]), 32'hFFFF00);
      chk("bars_h160", 32'(out_line[160]), 32'h00FFFF);
      chk("bars_h240", 32'(out_line[240]), 32'h00FF00);
      chk("bars_h320", 32'(out_line[320]), 32'hFF00FF);
      chk("bars_h400", 32'(out_line[400]), 32'hFF0000);
      chk("bars_h480", 32'(out_line[480]), 32'h0000FF);
      chk("bars_h560", 32'(out_line[560]), 32'h000000);
      chk("blank_h650", 32'(out_line[650]), 32'h000000);
      chk("fcnt_1", 32'(bus.frameCount), 32'd1);

      // Single inactive pixel mid-bar
      run_line(1, 200, -1, 3'd0, 1'b0);
      chk("hole_h199", 32'(out_line[199]), 32'h00FFFF);
      chk("hole_h200", 32'(out_line[200]), 32'h000000);
      chk("hole_h201", 32'(out_line[201]), 32'h00FFFF);

      // Mid-frame mode request waits for the next boundary
      run_line(10, -1, 100, 3'd2, 1'b0);
      chk("midchg_h99", 32'(out_line[99]), 32'hFFFF00);
      chk("midchg_h300", 32'(out_line[300]), 32'h00FF00);
      chk("midchg_mode", 32'(bus.activeMode), 32'd0);
      run_line(0, -1, -1, 3'd0, 1'b0);
      chk("chk_0_0", 32'(out_line[0]), 32'hFFFFFF);
      chk("chk_32_0", 32'(out_line[32]), 32'h000000);
      run_line(32, -1, -1, 3'd0, 1'b0);
      chk("chk_0_32", 32'(out_line[0]), 32'h000000);
      chk("chk_32_32", 32'(out_line[32]), 32'hFFFFFF);
      chk("chk_mode", 32'(bus.activeMode), 32'd2);
      chk("fcnt_2", 32'(bus.frameCount), 32'd2);

      // Grey ramp: hPos*256/640 truncated
      bus.patternMode = 3'd1;
      run_line(0, -1, -1, 3'd0, 1'b0);
      chk("ramp_h0", 32'(out_line[0]), 32'h000000);
      chk("ramp_h160", 32'(out_line[160]), 32'h404040);
      chk("ramp_h320", 32'(out_line[320]), 32'h808080);
      chk("ramp_h639", 32'(out_line[639]), 32'hFFFFFF);

      // Reserved mode renders black but is still reported
      bus.patternMode = 3'd5;
      run_line(0, -1, -1, 3'd0, 1'b0);
      chk("rsvd_h10", 32'(out_line[10]), 32'h000000);
      chk("rsvd_mode", 32'(bus.activeMode), 32'd5);

      // Solid colour latched at the boundary
      bus.patternMode = 3'd3;
      bus.solidColor  = 24'h123456;
      run_line(0, -1, -1, 3'd0, 1'b0);
      chk("solid_h10", 32'(out_line[10]), 32'h123456);
      bus.solidColor = 24'hABCDEF;
      run_line(5, -1, -1, 3'd0, 1'b0);
      chk("solid_hold", 32'(out_line[10]), 32'h123456);
      chk("fcnt_5", 32'(bus.frameCount), 32'd5);

      // Asynchronous reset mid-line
      for (int h = 0; h < 100; h++) pix(1'b1, h, 6);
      chk("prerst_rgb", 32'(rgb), 32'h123456);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_rgb", 32'(rgb), 32'h000000);
      chk("async_rst_mode", 32'(bus.activeMode), 32'd0);
      chk("async_rst_fcnt", 32'(bus.frameCount), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int h = 100; h < H_TOT; h++) pix(h < 640, h, 6);
      run_line(7, -1, -1, 3'd0, 1'b0);
      chk("postrst_h79", 32'(out_line[79]), 32'hFFFFFF);
      chk("postrst_h80", 32'(out_line[80]), 32'hFFFF00);
      chk("postrst_h400", 32'(out_line[400]), 32'hFF0000);
      chk("postrst_mode", 32'(bus.activeMode), 32'd0);
      run_line(0, -1, -1, 3'd0, 1'b0);
      chk("postrst_solid", 32'(out_line[10]), 32'hABCDEF);
      chk("postrst_mode3", 32'(bus.activeMode), 32'd3);
      chk("postrst_fcnt", 32'(bus.frameCount), 32'd1);

      // Moving bar: frame after boundary n shows the column at 4n, wrapping past 636
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.patternMode = 3'd4;
      run_line(0, -1, -1, 3'd0, 1'b0);
      chk("mov1_h3", 32'(out_line[3]), 32'h000000);
      chk("mov1_h4", 32'(out_line[4]), 32'hFFFFFF);
      chk("mov1_h11", 32'(out_line[11]), 32'hFFFFFF);
      chk("mov1_h12", 32'(out_line[12]), 32'h000000);
      repeat (157) boundary();
      run_line(0, -1, -1, 3'd0, 1'b1);
      chk("mov159_h0", 32'(out_line[0]), 32'h000000);
      chk("mov159_h635", 32'(out_line[635]), 32'h000000);
      chk("mov159_h636", 32'(out_line[636]), 32'hFFFFFF);
      chk("mov159_h639", 32'(out_line[639]), 32'hFFFFFF);
      chk("mov159_h640", 32'(out_line[640]), 32'h000000);
      chk("mov159_h643", 32'(out_line[643]), 32'h000000);
      run_line(0, -1, -1, 3'd0, 1'b0);
      chk("mov160_h0", 32'(out_line[0]), 32'hFFFFFF);
      chk("mov160_h7", 32'(out_line[7]), 32'hFFFFFF);
      chk("mov160_h8", 32'(out_line[8]), 32'h000000);
      boundary();
      chk("fcnt_161", 32'(bus.frameCount), 32'd161);
      chk("mov_mode", 32'(bus.activeMode), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
